// File: rtl/ddr_rd_burst_sched.sv
// rtl/ddr_rd_burst_sched.sv - AXI read-burst scheduler for a DDR sample ring region
// Issues one INCR read burst per committed write burst, bounded by outstanding-read budget.
module ddr_rd_burst_sched #(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0,
    parameter int                              REGION_BURSTS      = 1024,
    parameter int                              BURST_LEN          = 16,
    parameter int                              BEAT_BYTES         = 16,
    parameter int                              MAX_OUTSTANDING    = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     DDR_rd_en,
    input  logic                                     wr_burst_done,
    input  logic                                     flush,
    input  logic                                     fifo_full,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]            m_axi_araddr,
    output logic [7:0]                               m_axi_arlen,
    output logic [2:0]                               m_axi_arsize,
    output logic [1:0]                               m_axi_arburst,
    output logic                                     m_axi_arvalid,
    input  logic                                     m_axi_arready,
    input  logic                                     m_axi_rvalid,
    input  logic                                     m_axi_rlast,
    output logic                                     m_axi_rready,
    output logic [$clog2(REGION_BURSTS):0]           avail_bursts,
    output logic [3:0]                               outstanding,
    output logic                                     busy,
    output logic                                     overrun
);

    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int IDX_W   = $clog2(REGION_BURSTS);
    localparam int AVAIL_W = IDX_W + 1;

    localparam logic [AW-1:0]      BURST_BYTES = AW'(BURST_LEN * BEAT_BYTES);
    localparam logic [AVAIL_W-1:0] AVAIL_MAX   = AVAIL_W'(REGION_BURSTS);
    localparam logic [3:0]         OUT_MAX     = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [AVAIL_W-1:0]   avail_q, avail_d;
    logic [3:0]           out_q, out_d;
    logic                 overrun_q, overrun_d;

    logic ar_hs;
    logic r_done;
    logic wr_ok;

    assign ar_hs  = (state_q == ADDR) && m_axi_arready;
    assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    // Write commits are meaningless while the region is being discarded.
    assign wr_ok  = wr_burst_done && (state_q != DRAIN);

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        idx_d        = idx_q;
        avail_d      = avail_q;
        out_d        = out_q;
        overrun_d    = overrun_q;

        // Late rlast beats after a reset must not wrap the counter below zero.
        if (ar_hs && !r_done) begin
            out_d = out_q + 4'd1;
        end else if (!ar_hs && r_done && (out_q != 4'd0)) begin
            out_d = out_q - 4'd1;
        end

        if (ar_hs && !wr_ok) begin
            avail_d = avail_q - AVAIL_W'(1);
        end else if (wr_ok && !ar_hs) begin
            if (avail_q == AVAIL_MAX) begin
                overrun_d = 1'b1;
            end else begin
                avail_d = avail_q + AVAIL_W'(1);
            end
        end

        if (ar_hs) begin
            idx_d = idx_q + IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (DDR_rd_en && (avail_q != '0) && (out_q < OUT_MAX)) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (m_axi_arready) begin
                    state_d      = (flush_pend_q || flush) ? DRAIN : IDLE;
                    flush_pend_d = 1'b0;
                end
            end
            DRAIN: begin
                if (out_q == 4'd0) begin
                    state_d   = IDLE;
                    idx_d     = '0;
                    avail_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            idx_q        <= '0;
            avail_q      <= '0;
            out_q        <= 4'd0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            idx_q        <= idx_d;
            avail_q      <= avail_d;
            out_q        <= out_d;
            overrun_q    <= overrun_d;
        end
    end

    // Address derives from the registered index, so it is stable for the whole AR wait.
    assign m_axi_araddr  = BASE_ADDR + (AW'(idx_q) * BURST_BYTES);
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(BEAT_BYTES));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_rready  = ~fifo_full;

    assign avail_bursts = avail_q;
    assign outstanding  = out_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_ddr_rd_burst_sched.sv
// tb/tb_ddr_rd_burst_sched.sv - self-checking bench for ddr_rd_burst_sched
module tb_ddr_rd_burst_sched;

    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          RB   = 16;
    localparam int          MAXO = 4;
    localparam int          BB   = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr, fl, ff, ary, rv, rl;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, rready, busy, overrun;
    logic [4:0]  avail;
    logic [3:0]  outst;

    int n_tests = 0;
    int n_fail  = 0;

    ddr_rd_burst_sched #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .BASE_ADDR         (BASE),
        .REGION_BURSTS     (RB),
        .BURST_LEN         (16),
        .BEAT_BYTES        (16),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .DDR_rd_en    (rd_en),
        .wr_burst_done(wr),
        .flush        (fl),
        .fifo_full    (ff),
        .m_axi_araddr (araddr),
        .m_axi_arlen  (arlen),
        .m_axi_arsize (arsize),
        .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(ary),
        .m_axi_rvalid (rv),
        .m_axi_rlast  (rl),
        .m_axi_rready (rready),
        .avail_bursts (avail),
        .outstanding  (outst),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic wr, rd, ary, rv, rl, ff;
        logic e_arv;
        int   e_idx, e_av, e_out;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rd_en = 0; wr = 0; fl = 0; ff = 0; ary = 0; rv = 0; rl = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic pulse_wr(input int n);
        for (int i = 0; i < n; i++) begin
            wr = 1;
            step();
        end
        wr = 0;
    endtask

    task automatic wait_arvalid(input string name);
        int k;
        k = 0;
        while (!arvalid && k < 8) begin
            step();
            k++;
        end
        chk(name, arvalid, 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 8) begin
            step();
            k++;
        end
        chk(name, busy, 0);
    endtask

    int hs_cnt;
    int m_av, m_out, m_idx;
    logic m_over, m_arv, nxt_arv;
    logic hs, rdone;

    initial begin
        rst_n = 0;
        clear_inputs();

        //        wr rd ary rv rl ff  arv idx av out
        tbl[0]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 1, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        tbl[8]  = '{1, 1, 1, 0, 0, 0, 1, 1, 2, 1};
        tbl[9]  = '{1, 1, 1, 0, 0, 0, 0, 0, 2, 2};
        tbl[10] = '{0, 1, 1, 0, 0, 0, 1, 2, 2, 2};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 3};
        tbl[12] = '{0, 1, 1, 0, 0, 0, 1, 3, 1, 3};
        tbl[13] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 3};
        tbl[14] = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 3};
        tbl[15] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 2};

        do_reset();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_avail", avail, 0);
        chk("rst_outstanding", outst, 0);
        chk("rst_overrun", overrun, 0);
        chk("arlen", arlen, 15);
        chk("arsize", arsize, 4);
        chk("arburst", arburst, 1);

        // Table vectors: inputs held across one rising edge, outputs checked after it.
        for (int i = 0; i < 16; i++) begin
            wr = tbl[i].wr; rd_en = tbl[i].rd; ary = tbl[i].ary;
            rv = tbl[i].rv; rl = tbl[i].rl; ff = tbl[i].ff;
            step();
            chk($sformatf("tbl%0d_arvalid", i), arvalid, tbl[i].e_arv);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_arv);
            chk($sformatf("tbl%0d_avail", i), avail, tbl[i].e_av);
            chk($sformatf("tbl%0d_outstanding", i), outst, tbl[i].e_out);
            chk($sformatf("tbl%0d_rready", i), rready, !tbl[i].ff);
            chk($sformatf("tbl%0d_overrun", i), overrun, 0);
            if (tbl[i].e_arv)
                chk($sformatf("tbl%0d_araddr", i), araddr, BASE + tbl[i].e_idx * BB);
        end

        // Outstanding budget: 10 bursts available, no rlast -> exactly 4 ARs.
        do_reset();
        pulse_wr(10);
        chk("lim_avail10", avail, 10);
        rd_en = 1; ary = 1; hs_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (arvalid) begin
                chk("lim_araddr", araddr, BASE + hs_cnt * BB);
                hs_cnt++;
            end
            step();
        end
        chk("lim_ar_count", hs_cnt, MAXO);
        chk("lim_arvalid_held", arvalid, 0);
        chk("lim_outstanding", outst, MAXO);
        chk("lim_avail6", avail, 6);
        rv = 1; rl = 1;
        step();
        rv = 0; rl = 0;
        wait_arvalid("lim_fifth_ar");
        chk("lim_fifth_araddr", araddr, BASE + 4 * BB);
        step();
        chk("lim_outstanding_after5", outst, MAXO);

        // Region wrap and overrun.
        do_reset();
        pulse_wr(RB);
        chk("ovr_avail_full", avail, RB);
        chk("ovr_not_yet", overrun, 0);
        pulse_wr(1);
        chk("ovr_avail_sat", avail, RB);
        chk("ovr_set", overrun, 1);
        rd_en = 1; ary = 1; rv = 1; rl = 1; hs_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (arvalid) begin
                chk("wrap_araddr", araddr, BASE + (hs_cnt % RB) * BB);
                hs_cnt++;
            end
            step();
        end
        chk("wrap_ar_count", hs_cnt, RB);
        chk("wrap_avail0", avail, 0);
        pulse_wr(1);
        wait_arvalid("wrap_ar17");
        chk("wrap_araddr17", araddr, BASE);
        chk("ovr_sticky", overrun, 1);
        step();

        // Flush with two bursts outstanding.
        do_reset();
        pulse_wr(RB + 1);
        rd_en = 1; ary = 1;
        for (int c = 0; c < 20 && outst != 2; c++) step();
        chk("fl_outstanding2", outst, 2);
        fl = 1;
        step();
        fl = 0;
        chk("fl_busy", busy, 1);
        chk("fl_arvalid", arvalid, 0);
        wr = 1;
        step();
        wr = 0;
        chk("fl_wr_ignored", avail, RB - 2);
        for (int c = 0; c < 4; c++) begin
            chk("fl_no_ar", arvalid, 0);
            step();
        end
        rv = 1; rl = 1;
        step();
        chk("fl_out1", outst, 1);
        chk("fl_busy_out1", busy, 1);
        step();
        rv = 0; rl = 0;
        wait_idle("fl_drained");
        chk("fl_avail0", avail, 0);
        chk("fl_overrun0", overrun, 0);
        chk("fl_out0", outst, 0);
        ary = 0;
        pulse_wr(1);
        wait_arvalid("fl_next_ar");
        chk("fl_next_araddr", araddr, BASE);

        // Flush while the AR is still waiting for arready.
        fl = 1;
        step();
        fl = 0;
        chk("fla_ar_kept", arvalid, 1);
        ary = 1;
        step();
        ary = 0;
        chk("fla_arvalid0", arvalid, 0);
        chk("fla_busy", busy, 1);
        chk("fla_out1", outst, 1);
        rv = 1; rl = 1;
        step();
        rv = 0; rl = 0;
        wait_idle("fla_drained");
        pulse_wr(1);
        wait_arvalid("fla_next_ar");
        chk("fla_next_araddr", araddr, BASE);

        // Asynchronous reset while an AR is pending, then stray rlasts.
        #2;
        rst_n = 0;
        #1;
        chk("arst_arvalid", arvalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_avail", avail, 0);
        chk("arst_out", outst, 0);
        chk("arst_overrun", overrun, 0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        rv = 1; rl = 1;
        repeat (3) step();
        rv = 0; rl = 0;
        chk("arst_out_sat", outst, 0);
        chk("arst_arvalid_after", arvalid, 0);

        // Randomised traffic against a counting model of the region.
        do_reset();
        m_av = 0; m_out = 0; m_idx = 0; m_over = 0; m_arv = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_arvalid", arvalid, m_arv);
            chk("rnd_busy", busy, m_arv);
            chk("rnd_avail", avail, m_av);
            chk("rnd_out", outst, m_out);
            chk("rnd_overrun", overrun, m_over);
            chk("rnd_rready", rready, !ff);
            if (m_arv) chk("rnd_araddr", araddr, BASE + m_idx * BB);

            wr    = ($urandom % 100) < 30;
            rd_en = ($urandom % 100) < 85;
            ary   = ($urandom % 100) < 60;
            ff    = ($urandom % 100) < 20;
            rv    = ($urandom % 100) < 50;
            rl    = rv && (($urandom % 100) < 35);

            hs    = m_arv && ary;
            rdone = rv && !ff && rl;
            nxt_arv = m_arv ? !ary : (rd_en && m_av > 0 && m_out < MAXO);
            if (hs && !rdone) m_out++;
            else if (rdone && !hs && m_out > 0) m_out--;
            if (hs && !wr) m_av--;
            else if (wr && !hs) begin
                if (m_av == RB) m_over = 1;
                else m_av++;
            end
            if (hs) m_idx = (m_idx + 1) % RB;
            m_arv = nxt_arv;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
